// File: rtl/char_match_pkg.sv
// Shared types and default sizes for the streaming KMP character matcher.
package char_match_pkg;

    localparam int PKG_MAX_LEN = 8;
    localparam int PKG_CNT_W   = 16;
    localparam int PKG_IDX_W   = $clog2(PKG_MAX_LEN);
    localparam int PKG_LEN_W   = $clog2(PKG_MAX_LEN + 1);

    typedef logic [7:0] char_t;

    typedef enum logic [1:0] {
        IDLE,
        BUILD,
        RUN
    } state_e;

endpackage

// File: rtl/kmp_fail_builder.sv
// Sequential KMP prefix-function builder: one comparison step per cycle
// over the committed pattern, raising done in the cycle the table is complete.
module kmp_fail_builder
    import char_match_pkg::*;
#(
    parameter int MAX_LEN = PKG_MAX_LEN,
    parameter int IDX_W   = PKG_IDX_W,
    parameter int LEN_W   = PKG_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  char_t            pat  [MAX_LEN],
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] fail [MAX_LEN],
    output logic             done
);

    logic             busy_r;
    logic [LEN_W-1:0] i_r;
    logic [LEN_W-1:0] j_r;
    logic [IDX_W-1:0] i_ix;
    logic [IDX_W-1:0] j_ix;
    logic [IDX_W-1:0] jm1_ix;

    assign i_ix   = i_r[IDX_W-1:0];
    assign j_ix   = j_r[IDX_W-1:0];
    assign jm1_ix = IDX_W'(j_r - 1'b1);
    assign done   = busy_r && (i_r == len);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
            i_r    <= '0;
            j_r    <= '0;
            for (int n = 0; n < MAX_LEN; n++) begin
                fail[n] <= '0;
            end
        end else if (start) begin
            busy_r  <= 1'b1;
            i_r     <= LEN_W'(1);
            j_r     <= '0;
            fail[0] <= '0;
        end else if (busy_r) begin
            // i reaching len means every entry below it is final.
            if (i_r == len) begin
                busy_r <= 1'b0;
            end else if (pat[i_ix] == pat[j_ix]) begin
                fail[i_ix] <= j_r + 1'b1;
                j_r        <= j_r + 1'b1;
                i_r        <= i_r + 1'b1;
            end else if (j_r != '0) begin
                j_r <= fail[jm1_ix];
            end else begin
                fail[i_ix] <= '0;
                i_r        <= i_r + 1'b1;
            end
        end
    end

endmodule

// File: rtl/char_stream_matcher.sv
// Streaming KMP matcher: staged pattern load, sequential failure-table build,
// then valid/ready scanning with match position, count and prefix reporting.
module char_stream_matcher
    import char_match_pkg::*;
#(
    parameter int MAX_LEN = PKG_MAX_LEN,
    parameter int CNT_W   = PKG_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pat_we,
    input  logic [$clog2(MAX_LEN)-1:0]   pat_idx,
    input  logic [7:0]                   pat_char,
    input  logic [$clog2(MAX_LEN+1)-1:0] pat_len,
    input  logic                         pat_commit,
    output logic                         busy,
    input  logic                         i_valid,
    input  logic [7:0]                   i_char,
    output logic                         i_ready,
    output logic                         o_match,
    output logic [CNT_W-1:0]             o_match_pos,
    output logic [CNT_W-1:0]             o_match_cnt,
    output logic [$clog2(MAX_LEN+1)-1:0] o_prefix
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_e           state_r;
    logic             busy_r;
    logic             rdy_r;
    char_t            pat_stg  [MAX_LEN];
    char_t            pat_act  [MAX_LEN];
    char_t            stg_wr   [MAX_LEN];
    logic [LEN_W-1:0] fail_tab [MAX_LEN];
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] k_r;
    logic [LEN_W-1:0] k_nx;
    logic [LEN_W-1:0] k_inc;
    logic [CNT_W-1:0] pos_r;
    char_t            held_p0;
    char_t            c_cur;
    logic             stg_en;
    logic             commit_en;
    logic             bld_start;
    logic             bld_done;
    logic             take;
    logic             hit;
    logic             consume;
    logic             match;
    logic [IDX_W-1:0] k_ix;
    logic [IDX_W-1:0] km1_ix;
    logic [IDX_W-1:0] lm1_ix;

    assign stg_en    = pat_we && !busy_r;
    assign commit_en = pat_commit && !busy_r;
    assign bld_start = commit_en && (pat_len != '0);
    assign busy      = busy_r;
    assign i_ready   = rdy_r;
    assign o_prefix  = k_r;

    // A same-cycle write is folded in so a commit sees it.
    always_comb begin
        stg_wr = pat_stg;
        if (stg_en) begin
            stg_wr[pat_idx] = pat_char;
        end
    end

    kmp_fail_builder #(
        .MAX_LEN (MAX_LEN),
        .IDX_W   (IDX_W),
        .LEN_W   (LEN_W)
    ) u_bld (
        .clk   (clk),
        .rst   (rst),
        .start (bld_start),
        .pat   (pat_act),
        .len   (len_r),
        .fail  (fail_tab),
        .done  (bld_done)
    );

    // While i_ready is low the rejected character is re-evaluated from held_p0.
    always_comb begin
        k_ix    = k_r[IDX_W-1:0];
        km1_ix  = IDX_W'(k_r - 1'b1);
        lm1_ix  = IDX_W'(len_r - 1'b1);
        k_inc   = k_r + 1'b1;
        c_cur   = rdy_r ? i_char : held_p0;
        take    = (state_r == RUN) && (!rdy_r || i_valid);
        hit     = (pat_act[k_ix] == c_cur);
        consume = take && (hit || (k_r == '0));
        match   = take && hit && (k_inc == len_r);
        k_nx    = k_r;
        if (take) begin
            if (hit) begin
                k_nx = match ? fail_tab[lm1_ix] : k_inc;
            end else if (k_r != '0) begin
                k_nx = fail_tab[km1_ix];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            rdy_r       <= 1'b1;
            len_r       <= '0;
            k_r         <= '0;
            pos_r       <= '0;
            o_match     <= 1'b0;
            o_match_pos <= '0;
            o_match_cnt <= '0;
            for (int n = 0; n < MAX_LEN; n++) begin
                pat_stg[n] <= '0;
                pat_act[n] <= '0;
            end
        end else begin
            o_match <= 1'b0;
            if (stg_en) begin
                pat_stg <= stg_wr;
            end
            if (commit_en) begin
                k_r <= '0;
                if (pat_len == '0) begin
                    state_r <= IDLE;
                    len_r   <= '0;
                    rdy_r   <= 1'b1;
                end else begin
                    pat_act     <= stg_wr;
                    len_r       <= (pat_len > LEN_MAX) ? LEN_MAX : pat_len;
                    pos_r       <= '0;
                    o_match_pos <= '0;
                    o_match_cnt <= '0;
                    state_r     <= BUILD;
                    busy_r      <= 1'b1;
                    rdy_r       <= 1'b0;
                end
            end else begin
                case (state_r)
                    BUILD: begin
                        if (bld_done) begin
                            state_r <= RUN;
                            busy_r  <= 1'b0;
                            rdy_r   <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (take) begin
                            k_r   <= k_nx;
                            rdy_r <= consume;
                            if (consume) begin
                                pos_r <= pos_r + 1'b1;
                            end
                            if (match) begin
                                o_match     <= 1'b1;
                                o_match_pos <= pos_r;
                                if (o_match_cnt != '1) begin
                                    o_match_cnt <= o_match_cnt + 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take && !consume) begin
            held_p0 <= c_cur;
        end
    end

endmodule
